fifo_grant_gen_mc: RTL

- Synthesizable, multi-channel grant/back-pressure generator for the FIFO benches.
- Drives NUM_CH independent grant lines, one per FIFO consumer port.
- Modes: constant off, constant on, pseudo-random at programmable bandwidth, or deterministic on/off bursts.
- Deterministic LFSR randomness gives reproducible runs from a seed and replaces randcase.

---
 rtl/fifo_grant_gen_mc_pkg.sv | 25 ++
 rtl/fifo_grant_gen_mc_ch.sv | 142 ++++++++++++++
 rtl/fifo_grant_gen_mc.sv | 78 +++++++
 3 files changed

// File: rtl/fifo_grant_gen_mc_pkg.sv
// Shared types and constants for the multi-channel FIFO grant generator.
package fifo_grant_gen_mc_pkg;

    typedef enum logic [1:0] {
        GM_OFF   = 2'd0,
        GM_RAND  = 2'd1,
        GM_ON    = 2'd2,
        GM_BURST = 2'd3
    } grant_mode_e;

    typedef enum logic {
        BS_ON  = 1'b0,
        BS_OFF = 1'b1
    } burst_state_e;

    // Galois mask for x^16+x^14+x^13+x^11+1 (right-shifting form)
    localparam logic [15:0] GRANT_LFSR_POLY   = 16'hB400;
    localparam logic [15:0] GRANT_SEED_STRIDE = 16'h1F35;

    // Raw per-channel seed before truncation and zero substitution.
    function automatic logic [15:0] grant_seed(input logic [15:0] base, input int unsigned ch);
        return base ^ 16'(ch * 32'(GRANT_SEED_STRIDE));
    endfunction

endpackage

// File: rtl/fifo_grant_gen_mc_ch.sv
// One grant channel: free-running LFSR, burst on/off FSM and registered grant.
// Optional stall guard is built when FIFO_GRANT_GEN_STALL_GUARD_EN is defined.
module fifo_grant_gen_mc_ch
    import fifo_grant_gen_mc_pkg::*;
#(
    parameter int unsigned CH_IDX  = 0,
    parameter int unsigned BW_W    = 8,
    parameter int unsigned LFSR_W  = 16,
    parameter logic [15:0] SEED    = 16'hACE1,
    parameter int unsigned BURST_W = 8
`ifdef FIFO_GRANT_GEN_STALL_GUARD_EN
    ,
    parameter int unsigned MAX_STALL = 16
`endif
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_we,
    input  grant_mode_e        mode,
    input  logic [BW_W-1:0]    bw,
    input  logic [BURST_W-1:0] on_len,
    input  logic [BURST_W-1:0] off_len,
    input  logic               en,
    output logic               grant
`ifdef FIFO_GRANT_GEN_STALL_GUARD_EN
    ,
    output logic               stall_force
`endif
);

    localparam logic [LFSR_W-1:0]  POLY     = LFSR_W'(GRANT_LFSR_POLY);
    localparam logic [LFSR_W-1:0]  SEED_RAW = LFSR_W'(grant_seed(SEED, CH_IDX));
    localparam logic [LFSR_W-1:0]  SEED_CH  = (SEED_RAW == '0) ? LFSR_W'(1) : SEED_RAW;
    localparam logic [BURST_W-1:0] ONE      = BURST_W'(1);

    logic [LFSR_W-1:0]  lfsr_q, lfsr_d;
    burst_state_e       bstate_q, bstate_d;
    logic [BURST_W-1:0] bcnt_q, bcnt_d;
    logic               burst_on;
    logic               nat_grant;
    logic               grant_d;

`ifdef FIFO_GRANT_GEN_STALL_GUARD_EN
    localparam int unsigned STALL_W = $clog2(MAX_STALL + 1);
    logic [STALL_W-1:0] stall_q, stall_d;
    logic               force_d;
`endif

    // LFSR step and burst FSM next state; a config write restarts the burst in ON
    always_comb begin
        lfsr_d   = {1'b0, lfsr_q[LFSR_W-1:1]} ^ (lfsr_q[0] ? POLY : '0);
        bstate_d = bstate_q;
        bcnt_d   = bcnt_q;
        if (cfg_we) begin
            bstate_d = BS_ON;
            bcnt_d   = '0;
        end else if (en) begin
            case (bstate_q)
                BS_ON: begin
                    if (on_len == '0) begin
                        bstate_d = BS_OFF;
                        bcnt_d   = '0;
                    end else if (off_len == '0) begin
                        bcnt_d = bcnt_q;
                    end else if (bcnt_q == on_len - ONE) begin
                        bstate_d = BS_OFF;
                        bcnt_d   = '0;
                    end else begin
                        bcnt_d = bcnt_q + ONE;
                    end
                end
                BS_OFF: begin
                    if (on_len == '0) begin
                        bcnt_d = bcnt_q;
                    end else if ((off_len == '0) || (bcnt_q == off_len - ONE)) begin
                        bstate_d = BS_ON;
                        bcnt_d   = '0;
                    end else begin
                        bcnt_d = bcnt_q + ONE;
                    end
                end
                default: begin
                    bstate_d = BS_ON;
                    bcnt_d   = '0;
                end
            endcase
        end
    end

    // Natural grant from mode, then optional starvation override
    always_comb begin
        burst_on  = (bstate_q == BS_ON) && (on_len != '0);
        nat_grant = 1'b0;
        case (mode)
            GM_OFF:   nat_grant = 1'b0;
            GM_RAND:  nat_grant = (lfsr_q[BW_W-1:0] < bw);
            GM_ON:    nat_grant = 1'b1;
            GM_BURST: nat_grant = burst_on;
            default:  nat_grant = 1'b0;
        endcase
        nat_grant = nat_grant & en;
        grant_d   = nat_grant;
`ifdef FIFO_GRANT_GEN_STALL_GUARD_EN
        force_d = 1'b0;
        stall_d = '0;
        if (en && (mode != GM_OFF) && !nat_grant) begin
            if (stall_q == STALL_W'(MAX_STALL - 1)) begin
                grant_d = 1'b1;
                force_d = 1'b1;
            end else begin
                stall_d = stall_q + STALL_W'(1);
            end
        end
        if (cfg_we) begin
            stall_d = '0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q   <= SEED_CH;
            bstate_q <= BS_ON;
            bcnt_q   <= '0;
            grant    <= 1'b0;
`ifdef FIFO_GRANT_GEN_STALL_GUARD_EN
            stall_q     <= '0;
            stall_force <= 1'b0;
`endif
        end else begin
            lfsr_q   <= lfsr_d;
            bstate_q <= bstate_d;
            bcnt_q   <= bcnt_d;
            grant    <= grant_d;
`ifdef FIFO_GRANT_GEN_STALL_GUARD_EN
            stall_q     <= stall_d;
            stall_force <= force_d;
`endif
        end
    end

endmodule

// File: rtl/fifo_grant_gen_mc.sv
// Multi-channel grant/back-pressure generator: shared config registers, NUM_CH channels.
// Optional stall guard and stall_force_o port via FIFO_GRANT_GEN_STALL_GUARD_EN.
module fifo_grant_gen_mc
    import fifo_grant_gen_mc_pkg::*;
#(
    parameter int unsigned NUM_CH  = 4,
    parameter int unsigned BW_W    = 8,
    parameter int unsigned LFSR_W  = 16,
    parameter logic [15:0] SEED    = 16'hACE1,
    parameter int unsigned BURST_W = 8
`ifdef FIFO_GRANT_GEN_STALL_GUARD_EN
    ,
    parameter int unsigned MAX_STALL = 16
`endif
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_we,
    input  logic [1:0]         mode_i,
    input  logic [BW_W-1:0]    bw_i,
    input  logic [BURST_W-1:0] on_len_i,
    input  logic [BURST_W-1:0] off_len_i,
    input  logic [NUM_CH-1:0]  ch_en_i,
    output logic [NUM_CH-1:0]  grant_o
`ifdef FIFO_GRANT_GEN_STALL_GUARD_EN
    ,
    output logic [NUM_CH-1:0]  stall_force_o
`endif
);

    grant_mode_e        mode_q;
    logic [BW_W-1:0]    bw_q;
    logic [BURST_W-1:0] on_len_q;
    logic [BURST_W-1:0] off_len_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q    <= GM_OFF;
            bw_q      <= '0;
            on_len_q  <= '0;
            off_len_q <= '0;
        end else if (cfg_we) begin
            mode_q    <= grant_mode_e'(mode_i);
            bw_q      <= bw_i;
            on_len_q  <= on_len_i;
            off_len_q <= off_len_i;
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        fifo_grant_gen_mc_ch #(
            .CH_IDX   (32'(c)),
            .BW_W     (BW_W),
            .LFSR_W   (LFSR_W),
            .SEED     (SEED),
            .BURST_W  (BURST_W)
`ifdef FIFO_GRANT_GEN_STALL_GUARD_EN
            ,
            .MAX_STALL(MAX_STALL)
`endif
        ) u_ch (
            .clk        (clk),
            .rst_n      (rst_n),
            .cfg_we     (cfg_we),
            .mode       (mode_q),
            .bw         (bw_q),
            .on_len     (on_len_q),
            .off_len    (off_len_q),
            .en         (ch_en_i[c]),
            .grant      (grant_o[c])
`ifdef FIFO_GRANT_GEN_STALL_GUARD_EN
            ,
            .stall_force(stall_force_o[c])
`endif
        );
    end

endmodule
